// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-atomic arbiter sharing the UART TX FIFO write port between
// NUM_SRC byte-stream sources, with a mid-packet idle timeout that revokes the grant.
module uart_tx_arbiter #(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned HOLD_TIMEOUT = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_SRC-1:0]           src_valid,
  input  logic [8*NUM_SRC-1:0]         src_data,
  input  logic [NUM_SRC-1:0]           src_last,
  output logic [NUM_SRC-1:0]           src_ready,
  input  logic                         full,
  output logic                         fifo_write_req,
  output logic [7:0]                   fifo_write_data,
  output logic                         busy,
  output logic [$clog2(NUM_SRC)-1:0]   grant_id,
  output logic                         abort
);

  localparam int unsigned ID_W = $clog2(NUM_SRC);
  localparam int unsigned HC_W = $clog2(HOLD_TIMEOUT);

  typedef enum logic [1:0] {IDLE, LOAD, GAP} state_t;

  state_t              state, state_d;
  logic [ID_W-1:0]     last_grant, last_grant_d;
  logic [HC_W-1:0]     hold_cnt, hold_cnt_d;
  logic                last_q, last_d;
  logic [ID_W-1:0]     grant_id_d;
  logic                busy_d, wr_req_d, abort_d;
  logic [7:0]          wr_data_d;
  logic [NUM_SRC-1:0]  ready_d;

  logic                pick_found;
  logic [ID_W-1:0]     pick_id;
  logic [ID_W-1:0]     scan_idx;
  logic                cur_valid;
  logic                cur_last;
  logic [7:0]          cur_data;

  // First valid source scanning upward from last_grant+1 with wrap.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    scan_idx   = '0;
    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
      scan_idx = ID_W'((32'(last_grant) + i) % NUM_SRC);
      if (!pick_found && src_valid[scan_idx]) begin
        pick_found = 1'b1;
        pick_id    = scan_idx;
      end
    end
  end

  assign cur_valid = src_valid[grant_id];
  assign cur_last  = src_last[grant_id];
  assign cur_data  = src_data[{grant_id, 3'b000} +: 8];

  // Next-state and next-output logic; strobes default low so they last one cycle.
  always_comb begin
    state_d      = state;
    last_grant_d = last_grant;
    hold_cnt_d   = hold_cnt;
    last_d       = last_q;
    grant_id_d   = grant_id;
    busy_d       = busy;
    wr_req_d     = 1'b0;
    wr_data_d    = fifo_write_data;
    ready_d      = '0;
    abort_d      = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_found) begin
          grant_id_d   = pick_id;
          last_grant_d = pick_id;
          busy_d       = 1'b1;
          hold_cnt_d   = '0;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        if (cur_valid) begin
          if (!full) begin
            wr_req_d          = 1'b1;
            wr_data_d         = cur_data;
            ready_d[grant_id] = 1'b1;
            hold_cnt_d        = '0;
            last_d            = cur_last;
            state_d           = GAP;
          end
        end else if (hold_cnt == HC_W'(HOLD_TIMEOUT - 1)) begin
          abort_d    = 1'b1;
          busy_d     = 1'b0;
          hold_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          hold_cnt_d = hold_cnt + HC_W'(1);
        end
      end
      GAP: begin
        // One dead cycle lets the FIFO's full flag catch up with the write.
        if (last_q) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      last_grant      <= ID_W'(NUM_SRC - 1);
      hold_cnt        <= '0;
      last_q          <= 1'b0;
      grant_id        <= '0;
      busy            <= 1'b0;
      fifo_write_req  <= 1'b0;
      fifo_write_data <= '0;
      src_ready       <= '0;
      abort           <= 1'b0;
    end else begin
      state           <= state_d;
      last_grant      <= last_grant_d;
      hold_cnt        <= hold_cnt_d;
      last_q          <= last_d;
      grant_id        <= grant_id_d;
      busy            <= busy_d;
      fifo_write_req  <= wr_req_d;
      fifo_write_data <= wr_data_d;
      src_ready       <= ready_d;
      abort           <= abort_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: source models feed byte queues, expected
// writes are queued in predicted arbitration order and checked at each FIFO strobe.
module tb_uart_tx_arbiter;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned HT      = 16;

  typedef struct packed {
    logic [1:0] src;
    logic [7:0] data;
  } exp_t;

  logic                 clk;
  logic                 rst_n;
  logic [NUM_SRC-1:0]   src_valid;
  logic [8*NUM_SRC-1:0] src_data;
  logic [NUM_SRC-1:0]   src_last;
  logic [NUM_SRC-1:0]   src_ready;
  logic                 full;
  logic                 fifo_write_req;
  logic [7:0]           fifo_write_data;
  logic                 busy;
  logic [1:0]           grant_id;
  logic                 abort;

  uart_tx_arbiter #(.NUM_SRC(NUM_SRC), .HOLD_TIMEOUT(HT)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_valid(src_valid), .src_data(src_data), .src_last(src_last),
    .src_ready(src_ready), .full(full),
    .fifo_write_req(fifo_write_req), .fifo_write_data(fifo_write_data),
    .busy(busy), .grant_id(grant_id), .abort(abort)
  );

  logic [8:0] src_q [NUM_SRC][$];
  exp_t       exp_q [$];
  int         wr_cyc [$];
  int         n_chk = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         wr_cnt = 0;
  int         abort_cnt = 0;
  int         abort_cyc = 0;
  int         rdy3_cnt = 0;
  logic       full_prev = 1'b0;
  logic       rnd3;
  exp_t       e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic src_push(input int s, input logic [7:0] d, input logic last);
    src_q[s].push_back({last, d});
  endtask

  task automatic exp_push(input int s, input logic [7:0] d);
    exp_q.push_back('{src: 2'(s), data: d});
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < budget);
    check("idle", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) src_q[i].delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Source models: retire the front byte on src_ready, then present the next one.
  initial begin
    src_valid = '0;
    src_data  = '0;
    src_last  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_ready[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (rnd3 && i == 3 && src_q[2].size() > 1) begin
          src_valid[3]     = 1'($urandom);
          src_last[3]      = 1'($urandom);
          src_data[31:24]  = 8'($urandom);
        end else if (src_q[i].size() > 0) begin
          src_valid[i]      = 1'b1;
          src_last[i]       = src_q[i][0][8];
          src_data[8*i +: 8] = src_q[i][0][7:0];
        end else begin
          src_valid[i] = 1'b0;
          src_last[i]  = 1'b0;
        end
      end
    end
  end

  // Write monitor and scoreboard.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (fifo_write_req) begin
        wr_cnt++;
        wr_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("extra_wr", 32'(fifo_write_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("wr_data", 32'(fifo_write_data), 32'(e.data));
          check("wr_ready", 32'(src_ready), 32'(4'b0001 << e.src));
          check("wr_gid", 32'(grant_id), 32'(e.src));
        end
        check("wr_busy", 32'(busy), 32'd1);
        check("wr_nofull", 32'(full_prev), 32'd0);
      end else if (src_ready != '0) begin
        check("ready_no_wr", 32'(src_ready), 32'd0);
      end
      if (abort) begin
        abort_cnt++;
        abort_cyc = cyc;
        check("abort_busy", 32'(busy), 32'd0);
      end
      if (src_ready[3]) rdy3_cnt++;
    end
    full_prev = full;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    int drop;
    int a0;
    rst_n = 1'b0;
    full  = 1'b0;
    rnd3  = 1'b0;
    #1;
    check("rst_wr_req", 32'(fifo_write_req), 32'd0);
    check("rst_wr_data", 32'(fifo_write_data), 32'd0);
    check("rst_ready", 32'(src_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gid", 32'(grant_id), 32'd0);
    check("rst_abort", 32'(abort), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: three-byte packet from src0, strobes two cycles apart.
    wr_cyc.delete();
    src_push(0, 8'h41, 1'b0); exp_push(0, 8'h41);
    src_push(0, 8'h42, 1'b0); exp_push(0, 8'h42);
    src_push(0, 8'h43, 1'b1); exp_push(0, 8'h43);
    wait_drain(100);
    @(negedge clk);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_nwr", 32'(wr_cyc.size()), 32'd3);
    if (wr_cyc.size() == 3) begin
      check("t1_gap01", 32'(wr_cyc[1] - wr_cyc[0]), 32'd2);
      check("t1_gap12", 32'(wr_cyc[2] - wr_cyc[1]), 32'd2);
    end

    // 2: src1 vs src2 after reset, then a full rotation 3,0,1,2.
    do_reset();
    src_push(1, 8'h11, 1'b0); src_push(1, 8'h12, 1'b1);
    src_push(2, 8'h21, 1'b0); src_push(2, 8'h22, 1'b1);
    exp_push(1, 8'h11); exp_push(1, 8'h12); exp_push(2, 8'h21); exp_push(2, 8'h22);
    wait_drain(200);
    wait_idle(50);
    for (int i = 0; i < NUM_SRC; i++) src_push(i, 8'(8'hA0 + i), 1'b1);
    exp_push(3, 8'hA3); exp_push(0, 8'hA0); exp_push(1, 8'hA1); exp_push(2, 8'hA2);
    wait_drain(200);
    wait_idle(50);

    // 3: FIFO full for 10 cycles mid-packet.
    wr_cyc.delete();
    base = wr_cnt;
    for (int i = 0; i < 5; i++) begin
      src_push(1, 8'(8'h31 + i), 1'(i == 4));
      exp_push(1, 8'(8'h31 + i));
    end
    n = 0;
    while (wr_cnt < base + 2 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    full = 1'b1;
    base = wr_cnt;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    full = 1'b0;
    drop = cyc;
    check("t3_no_wr_full", 32'(wr_cnt - base), 32'd0);
    wait_drain(200);
    wait_idle(50);
    check("t3_nwr", 32'(wr_cyc.size()), 32'd5);
    if (wr_cyc.size() >= 3) check("t3_resume", 32'(wr_cyc[2] - drop), 32'd1);

    // 4: src0 stalls after its first byte; timeout hands the port to src1.
    wr_cyc.delete();
    a0 = abort_cnt;
    src_push(0, 8'h51, 1'b0); exp_push(0, 8'h51);
    src_push(1, 8'h61, 1'b1); exp_push(1, 8'h61);
    wait_drain(200);
    wait_idle(50);
    check("t4_abort_cnt", 32'(abort_cnt - a0), 32'd1);
    if (wr_cyc.size() == 2) begin
      check("t4_abort_lat", 32'(abort_cyc - wr_cyc[0]), 32'(HT + 1));
      check("t4_regrant", 32'(wr_cyc[1] - abort_cyc), 32'd2);
    end else begin
      check("t4_nwr", 32'(wr_cyc.size()), 32'd2);
    end

    // 5: async reset while the first byte's strobe is up.
    a0 = abort_cnt;
    src_push(0, 8'h71, 1'b0); exp_push(0, 8'h71);
    src_push(0, 8'h72, 1'b0);
    src_push(0, 8'h73, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fifo_write_req && n < 50);
    #2 rst_n = 1'b0;
    #1;
    check("t5_wr_req", 32'(fifo_write_req), 32'd0);
    check("t5_ready", 32'(src_ready), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_abort", 32'(abort), 32'd0);
    check("t5_first_wr", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < NUM_SRC; i++) src_q[i].delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    src_push(1, 8'h81, 1'b1);
    src_push(0, 8'h80, 1'b1);
    exp_push(0, 8'h80); exp_push(1, 8'h81);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_drain(200);
    wait_idle(50);
    check("t5_no_abort", 32'(abort_cnt - a0), 32'd0);

    // 6: src3 chatters while src2 owns the port.
    rdy3_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      src_push(2, 8'(8'h90 + i), 1'(i == 5));
      exp_push(2, 8'(8'h90 + i));
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(busy && grant_id == 2'd2) && n < 50);
    check("t6_grant2", 32'(grant_id), 32'd2);
    rnd3 = 1'b1;
    wait_drain(300);
    wait_idle(50);
    rnd3 = 1'b0;
    check("t6_no_ready3", 32'(rdy3_cnt), 32'd0);
    check("final_exp_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
